// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, AXI response codes and the
// access-size encodings that the LSU also uses.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_RESP,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // AXI size is log2(bytes); LSU size codes already are, so only widen.
    function automatic logic [2:0] axi_size(input logic [1:0] sz);
        return {1'b0, sz};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// AXI4-Lite read/write channels between the arbiter (master) and the
// SoC interconnect (slave).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arsize, arvalid, rready,
        output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arsize, arvalid, rready,
        input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Merges the IFU and LSU request ports onto one AXI4-Lite master, LSU first.
// Each requester owns one pending slot; a single transaction is in flight.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_reqValid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [1:0]          lsu_size,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                resp_err,
    mem_arbiter_if.master       m
);

    state_t              state, state_next;
    logic                ifu_pend, lsu_pend, owner_lsu;
    logic [ADDR_W-1:0]   ifu_addr_q, lsu_addr_q;
    logic [1:0]          lsu_size_q;
    logic                lsu_wen_q;
    logic [DATA_W-1:0]   lsu_wdata_q;
    logic [DATA_W/8-1:0] lsu_wmask_q;
    logic                aw_done, w_done, err_q;
    logic [31:0]         tmo_cnt;
    logic                busy, progress, tmo_fire, aw_fire, w_fire;
    logic                resp_ifu, resp_lsu;

    assign resp_ifu = (state == RESP) && !owner_lsu;
    assign resp_lsu = (state == RESP) && owner_lsu;
    assign aw_fire  = m.awvalid && m.awready;
    assign w_fire   = m.wvalid && m.wready;
    assign busy     = state inside {RD_ADDR, RD_DATA, WR_ADDR, WR_RESP};
    assign tmo_fire = (TIMEOUT > 0) && busy && !progress && (tmo_cnt == 32'(TIMEOUT - 1));

    // A slot stays pending through service, so repeat pulses are dropped.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifu_pend   <= 1'b0;
            ifu_addr_q <= '0;
        end else if (resp_ifu) begin
            ifu_pend   <= 1'b0;
        end else if (ifu_reqValid && !ifu_pend) begin
            ifu_pend   <= 1'b1;
            ifu_addr_q <= ifu_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lsu_pend    <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_size_q  <= SZ_B;
            lsu_wen_q   <= 1'b0;
            lsu_wdata_q <= '0;
            lsu_wmask_q <= '0;
        end else if (resp_lsu) begin
            lsu_pend    <= 1'b0;
        end else if (lsu_reqValid && !lsu_pend) begin
            lsu_pend    <= 1'b1;
            lsu_addr_q  <= lsu_addr;
            lsu_size_q  <= lsu_size;
            lsu_wen_q   <= lsu_wen;
            lsu_wdata_q <= lsu_wdata;
            lsu_wmask_q <= lsu_wmask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_lsu <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else if (state == IDLE) begin
            owner_lsu <= lsu_pend;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        progress = 1'b0;
        unique case (state)
            RD_ADDR: progress = m.arready;
            RD_DATA: progress = m.rvalid;
            WR_ADDR: progress = (aw_done || aw_fire) && (w_done || w_fire);
            WR_RESP: progress = m.bvalid;
            default: progress = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (lsu_pend)      state_next = lsu_wen_q ? WR_ADDR : RD_ADDR;
                else if (ifu_pend) state_next = RD_ADDR;
            end
            RD_ADDR: if (progress) state_next = RD_DATA;
            RD_DATA: if (progress) state_next = RESP;
            WR_ADDR: if (progress) state_next = WR_RESP;
            WR_RESP: if (progress) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (tmo_fire) state_next = RESP;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    tmo_cnt <= '0;
        else if (state_next != state) tmo_cnt <= '0;
        else if (busy)                tmo_cnt <= tmo_cnt + 32'd1;
    end

    // Response data is written straight into the owner's output register so it holds afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifu_rdata <= '0;
            lsu_rdata <= '0;
            err_q     <= 1'b0;
        end else if (state == RD_DATA && m.rvalid) begin
            err_q <= (m.rresp != RESP_OKAY);
            if (owner_lsu) lsu_rdata <= m.rdata;
            else           ifu_rdata <= m.rdata;
        end else if (state == WR_RESP && m.bvalid) begin
            err_q <= (m.bresp != RESP_OKAY);
        end else if (tmo_fire) begin
            err_q <= 1'b1;
            if (owner_lsu) lsu_rdata <= '0;
            else           ifu_rdata <= '0;
        end
    end

    assign m.araddr  = owner_lsu ? lsu_addr_q : ifu_addr_q;
    assign m.arsize  = owner_lsu ? axi_size(lsu_size_q) : axi_size(SZ_W);
    assign m.arvalid = (state == RD_ADDR);
    assign m.rready  = (state == RD_DATA);
    assign m.awaddr  = lsu_addr_q;
    assign m.awsize  = axi_size(lsu_size_q);
    assign m.awvalid = (state == WR_ADDR) && !aw_done;
    assign m.wdata   = lsu_wdata_q;
    assign m.wstrb   = lsu_wmask_q;
    assign m.wvalid  = (state == WR_ADDR) && !w_done;
    assign m.bready  = (state == WR_RESP);

    assign ifu_respValid = resp_ifu;
    assign lsu_respValid = resp_lsu;
    assign resp_err      = (state == RESP) && err_q;

endmodule
